// File: rtl/dm_bus_responder_if.sv
// Data-memory port between the core (master) and the memory/timer responder (slave).
interface dm_bus_responder_if;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata;

  modport master (
    output m_data_addr,
    output m_data_wdata,
    output m_data_byteen,
    input  m_data_rdata
  );

  modport slave (
    input  m_data_addr,
    input  m_data_wdata,
    input  m_data_byteen,
    output m_data_rdata
  );
endinterface

// File: rtl/dm_bus_responder.sv
// Data-memory responder: word RAM with byte-enable writes plus a memory-mapped
// countdown timer with level interrupt. Read data is combinational.
module dm_bus_responder #(
  parameter int unsigned RAM_WORDS  = 3072,
  parameter logic [31:0] TIMER_BASE = 32'h0000_7F00
) (
  input  logic                clk,
  input  logic                reset,
  dm_bus_responder_if.slave   bus,
  output logic                irq
);

  localparam int unsigned IDX_W       = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES   = 32'(4 * RAM_WORDS);
  localparam logic [29:0] CTRL_WORD   = TIMER_BASE[31:2];
  localparam logic [29:0] PRESET_WORD = CTRL_WORD + 30'd1;
  localparam logic [29:0] COUNT_WORD  = CTRL_WORD + 30'd2;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  logic [31:0]      ram [RAM_WORDS];
  logic [IDX_W-1:0] ram_idx;
  logic [29:0]      word;
  logic             wr, ram_hit, ctrl_sel, preset_sel, count_sel;
  logic             ctrl_we, preset_we;
  logic             unused_addr_bits;

  state_t      state_q;
  logic [3:0]  ctrl_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irq_flag_q;
  logic        mode_reload, flag_set, flag_nxt, im_nxt;

  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  // Address decode; the low two address bits do not select anything.
  assign word             = bus.m_data_addr[31:2];
  assign ram_idx          = bus.m_data_addr[IDX_W+1:2];
  assign unused_addr_bits = ^bus.m_data_addr[1:0];
  assign wr               = |bus.m_data_byteen;
  assign ram_hit          = bus.m_data_addr < RAM_BYTES;
  assign ctrl_sel         = !ram_hit && (word == CTRL_WORD);
  assign preset_sel       = !ram_hit && (word == PRESET_WORD);
  assign count_sel        = !ram_hit && (word == COUNT_WORD);
  assign ctrl_we          = ctrl_sel && wr;
  assign preset_we        = preset_sel && wr;

  always_comb begin
    bus.m_data_rdata = '0;
    if (ram_hit)         bus.m_data_rdata = ram[ram_idx];
    else if (ctrl_sel)   bus.m_data_rdata = {28'd0, ctrl_q};
    else if (preset_sel) bus.m_data_rdata = preset_q;
    else if (count_sel)  bus.m_data_rdata = count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RAM_WORDS; i++) ram[i] <= '0;
    end else if (ram_hit && wr) begin
      ram[ram_idx] <= byte_merge(ram[ram_idx], bus.m_data_wdata, bus.m_data_byteen);
    end
  end

  // A bus write to CTRL always clears the flag, even against a same-cycle set.
  assign mode_reload = (ctrl_q[2:1] == 2'b01);
  assign flag_set    = (state_q == S_CNT) && ctrl_q[0] && (count_q == '0);
  assign flag_nxt    = ctrl_we ? 1'b0 :
                       flag_set ? 1'b1 :
                       ((state_q == S_INT) && mode_reload) ? 1'b0 : irq_flag_q;
  assign im_nxt      = (ctrl_we && bus.m_data_byteen[0]) ? bus.m_data_wdata[3] : ctrl_q[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      irq        <= 1'b0;
    end else begin
      irq_flag_q <= flag_nxt;
      irq        <= flag_nxt & im_nxt;
      if (preset_we) preset_q <= byte_merge(preset_q, bus.m_data_wdata, bus.m_data_byteen);
      case (state_q)
        S_IDLE: if (ctrl_q[0]) state_q <= S_LOAD;
        S_LOAD: begin
          count_q <= preset_q;
          state_q <= S_CNT;
        end
        S_CNT: begin
          if (!ctrl_q[0])           state_q <= S_IDLE;
          else if (count_q != '0)   count_q <= count_q - 32'd1;
          else                      state_q <= S_INT;
        end
        S_INT: begin
          if (mode_reload) begin
            state_q <= S_LOAD;
          end else begin
            ctrl_q[0] <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // Written CTRL bits take precedence over the FSM's EN clear.
      if (ctrl_we && bus.m_data_byteen[0]) ctrl_q <= bus.m_data_wdata[3:0];
    end
  end

endmodule
